rtc_bus_sequencer: RTL

Parametrised transaction engine for the multiplexed address/data bus of the external RTC: a_d, cs, rd and wr strobes plus an 8-bit shared bus. Each command is one burst. A read burst fills a local register file from consecutive RTC addresses. A write burst sends register-file entries to the RTC. Pulse widths, register-file depth and the file index treated as "hour" are parameters. A registered 12/24-hour BCD view of the hour entry is provided for display. The block sits between the mode FSM and the display/configuration logic, replacing the fixed single-access pulse generator and the fixed-size register bank.

---
 rtl/rtc_bus_sequencer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_sequencer.sv
// Burst engine for the multiplexed RTC bus: each access is an address phase then a data phase,
// each phase being setup / strobe pulse / gap. Also keeps the local register file and a 12/24h hour view.
module rtc_bus_sequencer #(
  parameter  int DATA_W   = 8,
  parameter  int NREG     = 16,
  parameter  int T_SETUP  = 2,
  parameter  int T_PULSE  = 8,
  parameter  int T_GAP    = 4,
  parameter  int HOUR_IDX = 2,
  localparam int LEN_W    = $clog2(NREG + 1),
  localparam int IDX_W    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [7:0]        cmd_addr_i,
  input  logic [LEN_W-1:0]  cmd_len_i,
  output logic              a_d_o,
  output logic              cs_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [DATA_W-1:0] ad_out_o,
  output logic              ad_oe_o,
  input  logic [DATA_W-1:0] ad_in_i,
  input  logic              loc_we_i,
  input  logic [IDX_W-1:0]  loc_idx_i,
  input  logic [DATA_W-1:0] loc_wdata_i,
  output logic [DATA_W-1:0] loc_rdata_o,
  input  logic              fmt_12h_i,
  output logic [DATA_W-1:0] hour_disp_o,
  output logic              am_pm_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int T_MAX = (T_SETUP > T_PULSE) ? ((T_SETUP > T_GAP) ? T_SETUP : T_GAP)
                                             : ((T_PULSE > T_GAP) ? T_PULSE : T_GAP);
  localparam int CNT_W = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_SET, S_A_PUL, S_A_GAP, S_D_SET, S_D_PUL, S_D_GAP, S_FIN
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [7:0]         addr_q, addr_d;
  logic               write_q, write_d;
  logic [DATA_W-1:0]  hour_q;
  logic               pm_q;
  logic [DATA_W-1:0]  file_q [NREG];
  logic               tc, last, capture;
  logic [7:0]         bus_addr;

  assign tc       = (cnt_q == '0);
  assign last     = (LEN_W'(idx_q) + LEN_W'(1)) >= len_q;
  assign bus_addr = addr_q + 8'(idx_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = tc ? cnt_q : cnt_q - CNT_W'(1);
    idx_d    = idx_q;
    len_d    = len_q;
    addr_d   = addr_q;
    write_d  = write_q;
    cs_o     = 1'b1;
    rd_o     = 1'b1;
    wr_o     = 1'b1;
    a_d_o    = 1'b0;
    ad_oe_o  = 1'b0;
    ad_out_o = '0;
    done_o   = 1'b0;
    capture  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i) begin
          write_d = cmd_write_i;
          addr_d  = cmd_addr_i;
          len_d   = (cmd_len_i > LEN_W'(NREG)) ? LEN_W'(NREG) : cmd_len_i;
          idx_d   = '0;
          if (cmd_len_i == '0) begin
            state_d = S_FIN;
          end else begin
            state_d = S_A_SET;
            cnt_d   = CNT_W'(T_SETUP - 1);
          end
        end
      end
      S_A_SET, S_A_PUL: begin
        cs_o     = 1'b0;
        ad_oe_o  = 1'b1;
        ad_out_o = DATA_W'(bus_addr);
        wr_o     = (state_q != S_A_PUL);
        if (tc) begin
          state_d = (state_q == S_A_SET) ? S_A_PUL : S_A_GAP;
          cnt_d   = (state_q == S_A_SET) ? CNT_W'(T_PULSE - 1) : CNT_W'(T_GAP - 1);
        end
      end
      S_A_GAP: begin
        if (tc) begin
          state_d = S_D_SET;
          cnt_d   = CNT_W'(T_SETUP - 1);
        end
      end
      S_D_SET, S_D_PUL: begin
        cs_o     = 1'b0;
        a_d_o    = 1'b1;
        ad_oe_o  = write_q;
        ad_out_o = write_q ? file_q[idx_q] : '0;
        wr_o     = !(write_q && state_q == S_D_PUL);
        rd_o     = !(!write_q && state_q == S_D_PUL);
        capture  = !write_q && (state_q == S_D_PUL) && tc;
        if (tc) begin
          state_d = (state_q == S_D_SET) ? S_D_PUL : S_D_GAP;
          cnt_d   = (state_q == S_D_SET) ? CNT_W'(T_PULSE - 1) : CNT_W'(T_GAP - 1);
        end
      end
      S_D_GAP: begin
        a_d_o = 1'b1;
        if (tc) begin
          if (last) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_A_SET;
            cnt_d   = CNT_W'(T_SETUP - 1);
          end
        end
      end
      S_FIN: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // 12h: 00 -> 12 AM, 12 -> 12 PM, 13..23 -> minus twelve PM; anything not a valid hour shows 00 AM
  function automatic logic [DATA_W:0] hour_conv(input logic [DATA_W-1:0] h, input logic fmt);
    int hi, lo, bin;
    hi  = int'(h[7:4]);
    lo  = int'(h[3:0]);
    bin = 10 * hi + lo;
    if (!fmt)                                  return {1'b0, h};
    if (h > DATA_W'('h23) || hi > 9 || lo > 9) return '0;
    if (bin == 0)                              return {1'b0, DATA_W'('h12)};
    if (bin < 12)                              return {1'b0, h};
    if (bin == 12)                             return {1'b1, DATA_W'('h12)};
    bin = bin - 12;
    return {1'b1, DATA_W'((bin / 10) * 16 + (bin % 10))};
  endfunction

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      hour_q  <= '0;
      pm_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      addr_q         <= addr_d;
      write_q        <= write_d;
      {pm_q, hour_q} <= hour_conv(file_q[HOUR_IDX], fmt_12h_i);
    end
  end

  // Engine capture takes priority over a host write to the same entry
  always_ff @(posedge clk_i) begin
    for (int j = 0; j < NREG; j++) begin
      if (reset_i) begin
        file_q[j] <= '0;
      end else if (capture && idx_q == IDX_W'(j)) begin
        file_q[j] <= ad_in_i;
      end else if (loc_we_i && loc_idx_i == IDX_W'(j)) begin
        file_q[j] <= loc_wdata_i;
      end
    end
  end

  assign loc_rdata_o = (int'(loc_idx_i) < NREG) ? file_q[loc_idx_i] : '0;
  assign hour_disp_o = hour_q;
  assign am_pm_o     = pm_q;
  assign cmd_ready_o = (state_q == S_IDLE);
  assign busy_o      = (state_q != S_IDLE);

endmodule
